// File: rtl/isc_ack_arb_pkg.sv
// rtl/isc_ack_arb_pkg.sv - shared state enum and source-index width helper for isc_ack_arb
package isc_ack_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic int src_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/isc_ack_arb_cnt.sv
// rtl/isc_ack_arb_cnt.sv - per-source saturating ack counter with capture reload
module isc_ack_arb_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             a_rst_n,
    input  logic             inc,
    input  logic             clr_load,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             sat
);

    assign nz  = |cnt;
    assign sat = &cnt;

    // On capture the old count leaves with the record; a same-cycle pulse starts the next one.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            cnt <= '0;
        end else if (clr_load) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/isc_ack_arb.sv
// rtl/isc_ack_arb.sv - round-robin ack pulse aggregator; ISC_ACK_ARB_OVF_EN adds sticky ovf flags
module isc_ack_arb
    import isc_ack_arb_pkg::*;
#(
    parameter  int N_SRC = 4,
    parameter  int CNT_W = 4,
    localparam int SRC_W = src_w(N_SRC)
) (
    input  logic             clk,
    input  logic             a_rst_n,
    input  logic [N_SRC-1:0] in_pulse,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [SRC_W-1:0] out_src,
    output logic [CNT_W-1:0] out_cnt
`ifdef ISC_ACK_ARB_OVF_EN
    ,
    output logic [N_SRC-1:0] ovf
`endif
);

    state_t             state;
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   win;
    logic [SRC_W-1:0]   ptr_nxt;
    logic [SRC_W-1:0]   idx_s;
    int                 idx;
    logic               found;
    logic               any_nz;
    logic               cap;
    logic [N_SRC-1:0]   nz;
    logic [N_SRC-1:0]   sat;
    logic [N_SRC-1:0]   clr_load;
    logic [CNT_W-1:0]   cnt_q [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign clr_load[i] = cap && (win == SRC_W'(i));

        isc_ack_arb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk),
            .a_rst_n  (a_rst_n),
            .inc      (in_pulse[i]),
            .clr_load (clr_load[i]),
            .cnt      (cnt_q[i]),
            .nz       (nz[i]),
            .sat      (sat[i])
        );
    end

    // First non-empty source at or after ptr, wrapping past N_SRC-1.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        idx_s = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            idx_s = SRC_W'(idx);
            if (!found && nz[idx_s]) begin
                found = 1'b1;
                win   = idx_s;
            end
        end
    end

    assign any_nz  = |nz;
    assign cap     = any_nz && ((state == IDLE) || out_rdy);
    assign ptr_nxt = (win == SRC_W'(N_SRC - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state   <= IDLE;
            out_vld <= 1'b0;
            out_src <= '0;
            out_cnt <= '0;
            ptr     <= '0;
        end else if (cap) begin
            state   <= PRESENT;
            out_vld <= 1'b1;
            out_src <= win;
            out_cnt <= cnt_q[win];
            ptr     <= ptr_nxt;
        end else if ((state == PRESENT) && out_rdy) begin
            state   <= IDLE;
            out_vld <= 1'b0;
        end
    end

`ifdef ISC_ACK_ARB_OVF_EN
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            ovf <= '0;
        end else begin
            ovf <= ovf | (in_pulse & sat & ~clr_load);
        end
    end
`else
    logic sat_unused;
    assign sat_unused = ^sat;
`endif

endmodule
